rob_commit_ctrl: RTL and testbench
==================================

// Module: rob_commit_ctrl
// PURPOSE
//  Reorder-buffer controller that sequences the architectural register file.
//  Allocates ROB ids to decoded instructions, collects CDB results, and retires one entry per cycle in order.
//  Retiring drives the register file commit port (commit_config, rs_to_write_id/val, commit_rob_id).
//  On a mispredicted branch it drives rollback_config and redirect_pc.
// PARAMETERS
//  ROB_DEPTH  16  entries; power of two
//  ROB_IDX_W  4   log2(ROB_DEPTH); width of every rob id
//  XLEN       32  data width
// PORTS
//  clk              in   1     clock
//  rst_n            in   1     reset; synchronous, active-low
//  rdy              in   1     global enable; low = hold all state
//  alloc_valid      in   1     decoder requests an entry
//  alloc_rd         in   5     destination register (0 = no write)
//  alloc_is_br      in   1     entry is a conditional branch
//  alloc_pred_tk    in   1     predicted direction
//  alloc_ready      out  1     entry available this cycle
//  alloc_rob_id     out  4     id granted (= tail); decoder forwards it to RF rob_need
//  cdb_valid        in   1     result broadcast
//  cdb_rob_id       in   4     completing entry
//  cdb_val          in   XLEN  result value
//  cdb_taken        in   1     actual branch direction
//  cdb_target       in   XLEN  correct next pc for branches
//  q1_rob_id/q2_rob_id   in   4     operand lookups (from RF rs*_rob_entry)
//  q1_ready/q2_ready     out  1     value available
//  q1_val/q2_val         out  XLEN  value
//  commit_config    out  1     one-cycle retire pulse to RF
//  rs_to_write_id   out  5     retired rd
//  rs_to_write_val  out  XLEN  retired value
//  commit_rob_id    out  4     retired id
//  rollback_config  out  1     one-cycle flush pulse (RF, RS, LSB)
//  redirect_pc      out  XLEN  fetch target, valid with rollback_config
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge, overrides rdy): head=tail=0, count=0, all busy/ready bits 0; all registered outputs 0.
//  - State: circular buffer; head/tail wrap mod ROB_DEPTH; count is 5 bits (0..16).
//  - alloc_ready = rdy && count<ROB_DEPTH && !rollback_config (combinational); alloc_rob_id = tail.
//    Alloc fire: busy=1, ready=0, store rd/is_br/pred_tk; tail++.
//  - CDB: if busy[cdb_rob_id], set ready and store val/taken/target at the edge. Non-busy target: ignored.
//  - Retire: at an edge with count>0 && ready[head] && !rollback_config, register the retire outputs:
//    - commit_config=1 for exactly one cycle; also asserted for rd=0, which the RF ignores.
//    - rs_to_write_id/val and commit_rob_id=head.
//    - head++.
//  - Retire latency: CDB at edge E sets ready; retire edge is E+1; commit_config is high in the following cycle.
//  - Mispredict: retiring entry with is_br && taken!=pred_tk sets rollback_config=1 and redirect_pc=target in the same cycle as its commit pulse.
//    At the next edge: head=tail=count=0, all busy=0; alloc and CDB ignored during the rollback cycle.
//  - Simultaneous alloc+retire: count unchanged.
//  - Full: alloc_ready uses the registered count, so it stays 0 even in a cycle where a retire is also scheduled.
//  - Query: q_ready = busy&&ready[q] | (cdb_valid && cdb_rob_id==q); the CDB value is forwarded when matching.
//  - rdy=0: no state change; commit_config and rollback_config forced 0; registered data outputs hold.
// STRUCTURE
//  - Shared package/header rob_defs: ROB_DEPTH, ROB_IDX_W, XLEN, entry field widths.
//  - One sub-module, rob_query_port (combinational id lookup + CDB bypass), instantiated twice for q1/q2.
//  - All else inline: pointer/count logic, entry arrays, retire/rollback output registers.
// TESTING
//  1. Reset: rst_n=0 for 2 clk -> alloc_ready=1, alloc_rob_id=0, commit_config=0, rollback_config=0.
//  2. Out-of-order completion:
//     - Stimulus: alloc rd=5 (id0), rd=6 (id1); CDB id1=0x22, then id0=0x11.
//     - Response: pulse (x5,0x11,id0), then next cycle (x6,0x22,id1).
//  3. Full/wrap: 16 allocs, no CDB -> alloc_ready=0, 17th ignored; complete+retire id0 -> alloc_ready=1, alloc_rob_id=0.
//  4. Mispredict:
//     - Stimulus: branch pred_tk=0 at id2; CDB taken=1 target=0x100.
//     - Response: commit and rollback pulses with redirect_pc=0x100; next cycle count=0, alloc_rob_id=0.
//  5. Bypass: q1_rob_id=3 while cdb_valid id3 val=0xABCD -> same-cycle q1_ready=1, q1_val=0xABCD.
//  6. Stall: head ready, rdy=0 for 3 cycles -> no commit pulse; pulse 1 cycle after rdy=1; rst_n=0 mid-stall clears all.

Source files
------------

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared sizes, types and helpers for the reorder-buffer commit controller.
package rob_commit_ctrl_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;
  localparam int XLEN      = 32;
  localparam int REG_W     = 5;
  localparam int CNT_W     = ROB_IDX_W + 1;

  typedef logic [ROB_IDX_W-1:0] rob_id_t;
  typedef logic [REG_W-1:0]     reg_id_t;
  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [CNT_W-1:0]     rob_cnt_t;

  // Per-entry bookkeeping; the result value lives in its own array for the query ports.
  typedef struct packed {
    reg_id_t rd;
    logic    is_br;
    logic    pred_tk;
    logic    taken;
    xlen_t   target;
  } rob_entry_t;

  function automatic logic is_mispredict(input rob_entry_t e);
    return e.is_br && (e.taken != e.pred_tk);
  endfunction

endpackage

// File: rtl/rob_query_port.sv
// Operand lookup by ROB id, with same-cycle bypass from the CDB broadcast.
module rob_query_port
  import rob_commit_ctrl_pkg::*;
(
  input  logic [ROB_IDX_W-1:0] q_rob_id,
  input  logic [ROB_DEPTH-1:0] busy,
  input  logic [ROB_DEPTH-1:0] ready,
  input  logic [XLEN-1:0]      val_tbl [ROB_DEPTH],
  input  logic                 cdb_valid,
  input  logic [ROB_IDX_W-1:0] cdb_rob_id,
  input  logic [XLEN-1:0]      cdb_val,
  output logic                 q_ready,
  output logic [XLEN-1:0]      q_val
);

  logic cdb_hit;

  assign cdb_hit = cdb_valid && (cdb_rob_id == q_rob_id);
  assign q_ready = (busy[q_rob_id] && ready[q_rob_id]) || cdb_hit;
  assign q_val   = cdb_hit ? cdb_val : val_tbl[q_rob_id];

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder buffer: allocates ids, collects CDB results, retires in order and
// flushes everything when a retiring branch turns out mispredicted.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 alloc_valid,
  input  logic [REG_W-1:0]     alloc_rd,
  input  logic                 alloc_is_br,
  input  logic                 alloc_pred_tk,
  output logic                 alloc_ready,
  output logic [ROB_IDX_W-1:0] alloc_rob_id,
  input  logic                 cdb_valid,
  input  logic [ROB_IDX_W-1:0] cdb_rob_id,
  input  logic [XLEN-1:0]      cdb_val,
  input  logic                 cdb_taken,
  input  logic [XLEN-1:0]      cdb_target,
  input  logic [ROB_IDX_W-1:0] q1_rob_id,
  input  logic [ROB_IDX_W-1:0] q2_rob_id,
  output logic                 q1_ready,
  output logic                 q2_ready,
  output logic [XLEN-1:0]      q1_val,
  output logic [XLEN-1:0]      q2_val,
  output logic                 commit_config,
  output logic [REG_W-1:0]     rs_to_write_id,
  output logic [XLEN-1:0]      rs_to_write_val,
  output logic [ROB_IDX_W-1:0] commit_rob_id,
  output logic                 rollback_config,
  output logic [XLEN-1:0]      redirect_pc
);

  rob_id_t              head_q, head_d, tail_q, tail_d;
  rob_cnt_t             count_q, count_d;
  logic [ROB_DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
  rob_entry_t           entry_q [ROB_DEPTH];
  rob_entry_t           entry_d [ROB_DEPTH];
  xlen_t                val_q   [ROB_DEPTH];
  xlen_t                val_d   [ROB_DEPTH];

  logic    commit_config_q, commit_config_d;
  reg_id_t rs_to_write_id_q, rs_to_write_id_d;
  xlen_t   rs_to_write_val_q, rs_to_write_val_d;
  rob_id_t commit_rob_id_q, commit_rob_id_d;
  logic    rollback_config_q, rollback_config_d;
  xlen_t   redirect_pc_q, redirect_pc_d;

  logic       alloc_fire, cdb_fire, retire_fire;
  rob_entry_t head_ent;

  // The flush cycle blocks alloc, CDB writes and retire; rdy low blocks everything.
  always_comb begin
    alloc_ready = rdy && (count_q < rob_cnt_t'(ROB_DEPTH)) && !rollback_config_q;
    alloc_fire  = alloc_valid && alloc_ready;
    cdb_fire    = rdy && !rollback_config_q && cdb_valid && busy_q[cdb_rob_id];
    retire_fire = rdy && !rollback_config_q && (count_q != '0) && ready_q[head_q];
    head_ent    = entry_q[head_q];
  end

  always_comb begin
    // NOTE: every _d takes its _q value first, so no path through this block infers a latch.
    head_d            = head_q;
    tail_d            = tail_q;
    busy_d            = busy_q;
    ready_d           = ready_q;
    entry_d           = entry_q;
    val_d             = val_q;
    commit_config_d   = 1'b0;
    rollback_config_d = 1'b0;
    rs_to_write_id_d  = rs_to_write_id_q;
    rs_to_write_val_d = rs_to_write_val_q;
    commit_rob_id_d   = commit_rob_id_q;
    redirect_pc_d     = redirect_pc_q;

    if (cdb_fire) begin
      ready_d[cdb_rob_id]        = 1'b1;
      val_d[cdb_rob_id]          = cdb_val;
      entry_d[cdb_rob_id].taken  = cdb_taken;
      entry_d[cdb_rob_id].target = cdb_target;
    end

    if (alloc_fire) begin
      busy_d[tail_q]          = 1'b1;
      ready_d[tail_q]         = 1'b0;
      entry_d[tail_q].rd      = alloc_rd;
      entry_d[tail_q].is_br   = alloc_is_br;
      entry_d[tail_q].pred_tk = alloc_pred_tk;
      tail_d                  = tail_q + rob_id_t'(1);
    end

    if (retire_fire) begin
      busy_d[head_q]    = 1'b0;
      ready_d[head_q]   = 1'b0;
      head_d            = head_q + rob_id_t'(1);
      commit_config_d   = 1'b1;
      rs_to_write_id_d  = head_ent.rd;
      rs_to_write_val_d = val_q[head_q];
      commit_rob_id_d   = head_q;
      if (is_mispredict(head_ent)) begin
        rollback_config_d = 1'b1;
        redirect_pc_d     = head_ent.target;
      end
    end

    count_d = count_q + rob_cnt_t'(alloc_fire) - rob_cnt_t'(retire_fire);

    if (rdy && rollback_config_q) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = '0;
      ready_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      busy_q            <= '0;
      ready_q           <= '0;
      commit_config_q   <= 1'b0;
      rs_to_write_id_q  <= '0;
      rs_to_write_val_q <= '0;
      commit_rob_id_q   <= '0;
      rollback_config_q <= 1'b0;
      redirect_pc_q     <= '0;
    end else begin
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      busy_q            <= busy_d;
      ready_q           <= ready_d;
      commit_config_q   <= commit_config_d;
      rs_to_write_id_q  <= rs_to_write_id_d;
      rs_to_write_val_q <= rs_to_write_val_d;
      commit_rob_id_q   <= commit_rob_id_d;
      rollback_config_q <= rollback_config_d;
      redirect_pc_q     <= redirect_pc_d;
    end
  end

  // NOTE: payload arrays are not reset; busy/ready gate every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
    val_q   <= val_d;
  end

  assign alloc_rob_id    = tail_q;
  assign commit_config   = commit_config_q;
  assign rs_to_write_id  = rs_to_write_id_q;
  assign rs_to_write_val = rs_to_write_val_q;
  assign commit_rob_id   = commit_rob_id_q;
  assign rollback_config = rollback_config_q;
  assign redirect_pc     = redirect_pc_q;

  rob_query_port u_q1 (
    .q_rob_id   (q1_rob_id),
    .busy       (busy_q),
    .ready      (ready_q),
    .val_tbl    (val_q),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_val    (cdb_val),
    .q_ready    (q1_ready),
    .q_val      (q1_val)
  );

  rob_query_port u_q2 (
    .q_rob_id   (q2_rob_id),
    .busy       (busy_q),
    .ready      (ready_q),
    .val_tbl    (val_q),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_val    (cdb_val),
    .q_ready    (q2_ready),
    .q_val      (q2_val)
  );

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: a vector table for in-order retire plus
// hand-written sequences for full/wrap, mispredict, bypass and stall/reset.
module tb_rob_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        alloc_valid, alloc_is_br, alloc_pred_tk, alloc_ready;
  logic [4:0]  alloc_rd;
  logic [3:0]  alloc_rob_id;
  logic        cdb_valid, cdb_taken;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_val, cdb_target;
  logic [3:0]  q1_rob_id, q2_rob_id;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic        commit_config, rollback_config;
  logic [4:0]  rs_to_write_id;
  logic [31:0] rs_to_write_val, redirect_pc;
  logic [3:0]  commit_rob_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rob_commit_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdy             (rdy),
    .alloc_valid     (alloc_valid),
    .alloc_rd        (alloc_rd),
    .alloc_is_br     (alloc_is_br),
    .alloc_pred_tk   (alloc_pred_tk),
    .alloc_ready     (alloc_ready),
    .alloc_rob_id    (alloc_rob_id),
    .cdb_valid       (cdb_valid),
    .cdb_rob_id      (cdb_rob_id),
    .cdb_val         (cdb_val),
    .cdb_taken       (cdb_taken),
    .cdb_target      (cdb_target),
    .q1_rob_id       (q1_rob_id),
    .q2_rob_id       (q2_rob_id),
    .q1_ready        (q1_ready),
    .q2_ready        (q2_ready),
    .q1_val          (q1_val),
    .q2_val          (q2_val),
    .commit_config   (commit_config),
    .rs_to_write_id  (rs_to_write_id),
    .rs_to_write_val (rs_to_write_val),
    .commit_rob_id   (commit_rob_id),
    .rollback_config (rollback_config),
    .redirect_pc     (redirect_pc)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic        cv;
    logic [3:0]  cid;
    logic [31:0] cval;
    logic        exp_ar;
    logic [3:0]  exp_aid;
    logic        exp_commit;
    logic [4:0]  exp_rd;
    logic [31:0] exp_val;
    logic [3:0]  exp_cid;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid   = 1'b0;
    alloc_rd      = '0;
    alloc_is_br   = 1'b0;
    alloc_pred_tk = 1'b0;
    cdb_valid     = 1'b0;
    cdb_rob_id    = '0;
    cdb_val       = '0;
    cdb_taken     = 1'b0;
    cdb_target    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy   = 1'b1;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic is_br, input logic pred_tk);
    alloc_valid   = 1'b1;
    alloc_rd      = rd;
    alloc_is_br   = is_br;
    alloc_pred_tk = pred_tk;
    step();
    idle_inputs();
  endtask

  task automatic drive_cdb(input logic [3:0] id, input logic [31:0] val,
                           input logic taken, input logic [31:0] target);
    cdb_valid  = 1'b1;
    cdb_rob_id = id;
    cdb_val    = val;
    cdb_taken  = taken;
    cdb_target = target;
  endtask

  initial begin
    q1_rob_id = '0;
    q2_rob_id = '0;

    // av ard cv cid cval | exp_ar exp_aid | exp_commit exp_rd exp_val exp_cid
    vecs[0]  = '{1'b1, 5'd5, 1'b0, 4'd0, 32'h0,     1'b1, 4'd0, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[1]  = '{1'b1, 5'd6, 1'b0, 4'd0, 32'h0,     1'b1, 4'd1, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[2]  = '{1'b0, 5'd0, 1'b1, 4'd1, 32'h22,    1'b1, 4'd2, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[3]  = '{1'b0, 5'd0, 1'b1, 4'd0, 32'h11,    1'b1, 4'd2, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[4]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,     1'b1, 4'd2, 1'b1, 5'd5, 32'h11, 4'd0};
    vecs[5]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,     1'b1, 4'd2, 1'b1, 5'd6, 32'h22, 4'd1};
    vecs[6]  = '{1'b0, 5'd0, 1'b1, 4'd7, 32'hdead,  1'b1, 4'd2, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[7]  = '{1'b1, 5'd0, 1'b0, 4'd0, 32'h0,     1'b1, 4'd2, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[8]  = '{1'b0, 5'd0, 1'b1, 4'd2, 32'h33,    1'b1, 4'd3, 1'b0, 5'd0, 32'h0,  4'd0};
    vecs[9]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,     1'b1, 4'd3, 1'b1, 5'd0, 32'h33, 4'd2};
    vecs[10] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,     1'b1, 4'd3, 1'b0, 5'd0, 32'h0,  4'd0};

    // Reset state
    do_reset();
    check("reset alloc_ready", 32'(alloc_ready), 32'd1);
    check("reset alloc_rob_id", 32'(alloc_rob_id), 32'd0);
    check("reset commit_config", 32'(commit_config), 32'd0);
    check("reset rollback_config", 32'(rollback_config), 32'd0);
    check("reset rs_to_write_val", rs_to_write_val, 32'd0);
    check("reset redirect_pc", redirect_pc, 32'd0);

    // Out-of-order completion, in-order retire, rd=0 retire, CDB to idle id
    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      alloc_valid = vecs[i].av;
      alloc_rd    = vecs[i].ard;
      cdb_valid   = vecs[i].cv;
      cdb_rob_id  = vecs[i].cid;
      cdb_val     = vecs[i].cval;
      #1;
      check($sformatf("v%0d alloc_ready", i), 32'(alloc_ready), 32'(vecs[i].exp_ar));
      check($sformatf("v%0d alloc_rob_id", i), 32'(alloc_rob_id), 32'(vecs[i].exp_aid));
      @(posedge clk);
      #1;
      idle_inputs();
      check($sformatf("v%0d commit_config", i), 32'(commit_config), 32'(vecs[i].exp_commit));
      if (vecs[i].exp_commit) begin
        check($sformatf("v%0d rs_to_write_id", i), 32'(rs_to_write_id), 32'(vecs[i].exp_rd));
        check($sformatf("v%0d rs_to_write_val", i), rs_to_write_val, vecs[i].exp_val);
        check($sformatf("v%0d commit_rob_id", i), 32'(commit_rob_id), 32'(vecs[i].exp_cid));
      end
    end

    // Full and wrap
    do_reset();
    for (int i = 0; i < 16; i++) alloc(5'(i + 1), 1'b0, 1'b0);
    #1;
    check("full alloc_ready", 32'(alloc_ready), 32'd0);
    check("full alloc_rob_id wrapped", 32'(alloc_rob_id), 32'd0);
    alloc(5'd31, 1'b0, 1'b0);
    drive_cdb(4'd0, 32'h55, 1'b0, 32'h0);
    step();
    idle_inputs();
    #1;
    check("full alloc_ready with retire pending", 32'(alloc_ready), 32'd0);
    step();
    check("wrap commit_config", 32'(commit_config), 32'd1);
    check("wrap rs_to_write_id (17th alloc ignored)", 32'(rs_to_write_id), 32'd1);
    check("wrap rs_to_write_val", rs_to_write_val, 32'h55);
    check("wrap commit_rob_id", 32'(commit_rob_id), 32'd0);
    check("wrap alloc_ready", 32'(alloc_ready), 32'd1);
    check("wrap alloc_rob_id", 32'(alloc_rob_id), 32'd0);
    step();
    check("wrap no second commit", 32'(commit_config), 32'd0);

    // Mispredict
    do_reset();
    alloc(5'd1, 1'b0, 1'b0);
    alloc(5'd2, 1'b0, 1'b0);
    alloc(5'd0, 1'b1, 1'b0);
    alloc(5'd3, 1'b0, 1'b0);
    drive_cdb(4'd0, 32'd1, 1'b0, 32'h0);
    step();
    drive_cdb(4'd1, 32'd2, 1'b0, 32'h0);
    step();
    check("br commit id0", 32'(commit_rob_id), 32'd0);
    check("br no early rollback", 32'(rollback_config), 32'd0);
    drive_cdb(4'd2, 32'd0, 1'b1, 32'h100);
    step();
    idle_inputs();
    check("br commit id1", 32'(commit_rob_id), 32'd1);
    step();
    check("mispredict commit_config", 32'(commit_config), 32'd1);
    check("mispredict commit_rob_id", 32'(commit_rob_id), 32'd2);
    check("mispredict rollback_config", 32'(rollback_config), 32'd1);
    check("mispredict redirect_pc", redirect_pc, 32'h100);
    alloc_valid = 1'b1;
    alloc_rd    = 5'd9;
    drive_cdb(4'd3, 32'h99, 1'b0, 32'h0);
    #1;
    check("rollback blocks alloc", 32'(alloc_ready), 32'd0);
    step();
    idle_inputs();
    q1_rob_id = 4'd3;
    #1;
    check("post-flush rollback_config", 32'(rollback_config), 32'd0);
    check("post-flush commit_config", 32'(commit_config), 32'd0);
    check("post-flush alloc_rob_id", 32'(alloc_rob_id), 32'd0);
    check("post-flush alloc_ready", 32'(alloc_ready), 32'd1);
    check("post-flush id3 not ready", 32'(q1_ready), 32'd0);
    step();
    check("post-flush no commit", 32'(commit_config), 32'd0);

    // Query bypass
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(10 + i), 1'b0, 1'b0);
    q1_rob_id = 4'd3;
    q2_rob_id = 4'd7;
    #1;
    check("q1 busy not ready", 32'(q1_ready), 32'd0);
    drive_cdb(4'd3, 32'hABCD, 1'b0, 32'h0);
    #1;
    check("q1 bypass ready", 32'(q1_ready), 32'd1);
    check("q1 bypass val", q1_val, 32'hABCD);
    check("q2 idle id not ready", 32'(q2_ready), 32'd0);
    step();
    idle_inputs();
    #1;
    check("q1 stored ready", 32'(q1_ready), 32'd1);
    check("q1 stored val", q1_val, 32'hABCD);

    // Stall with head ready, then reset in the middle of a stall
    drive_cdb(4'd0, 32'h77, 1'b0, 32'h0);
    step();
    idle_inputs();
    check("stall pre commit", 32'(commit_config), 32'd0);
    rdy = 1'b0;
    #1;
    check("stall alloc_ready", 32'(alloc_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall cycle %0d commit", i), 32'(commit_config), 32'd0);
    end
    rdy = 1'b1;
    step();
    check("resume commit_config", 32'(commit_config), 32'd1);
    check("resume commit_rob_id", 32'(commit_rob_id), 32'd0);
    check("resume rs_to_write_id", 32'(rs_to_write_id), 32'd10);
    check("resume rs_to_write_val", rs_to_write_val, 32'h77);
    step();
    check("resume single pulse", 32'(commit_config), 32'd0);
    drive_cdb(4'd1, 32'h88, 1'b0, 32'h0);
    step();
    idle_inputs();
    rdy   = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rdy   = 1'b1;
    q1_rob_id = 4'd3;
    #1;
    check("stall-reset alloc_ready", 32'(alloc_ready), 32'd1);
    check("stall-reset alloc_rob_id", 32'(alloc_rob_id), 32'd0);
    check("stall-reset commit_config", 32'(commit_config), 32'd0);
    check("stall-reset rs_to_write_val", rs_to_write_val, 32'd0);
    check("stall-reset q1 cleared", 32'(q1_ready), 32'd0);
    step();
    check("stall-reset no commit", 32'(commit_config), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
